// File: rtl/vga_timing.sv
// -----------------------------------------------------------------------------
// vga_timing
//
// Single-clock VGA raster timing generator. One horizontal/vertical counter
// pair produces sync, blanking, active-video and pixel coordinates for the
// downstream colour stage. That stage consumes o_x, o_y and o_active in the
// same i_clk cycle they are presented.
//
// Every output is a flop. Flags are decoded from the *next* counter value, so
// they land in the same register stage as the coordinates they describe. The
// sync/blank/active levels therefore always match the o_x/o_y shown alongside
// them, with no one-pixel skew.
//
// Ports
//   i_clk          system clock
//   i_rst          synchronous reset, active-high; overrides i_pix_en
//   i_pix_en       pixel-rate enable; counters advance only when set
//   o_hsync        horizontal sync, asserted at level SYNC_POL
//   o_vsync        vertical sync, asserted at level SYNC_POL
//   o_hblank       1 when the horizontal count is >= H_ACTIVE
//   o_vblank       1 when the vertical count is >= V_ACTIVE
//   o_active       ~o_hblank & ~o_vblank
//   o_x            current horizontal count, 0..H_TOTAL-1
//   o_y            current vertical count,   0..V_TOTAL-1
//   o_line_start   one-cycle pulse after the enabled edge that wrapped h to 0
//   o_frame_start  one-cycle pulse after the enabled edge that wrapped (h,v)
//   o_frame_cnt    16-bit count of frames started (optional, see below)
//
// Optional feature
//   Define VGA_TIMING_FRAME_CNT_EN to add o_frame_cnt. The 16-bit counter
//   steps in the same cycle o_frame_start is high and wraps 65535 -> 0.
//   Without the macro, both the port and the counter are absent.
// -----------------------------------------------------------------------------
module vga_timing #(
  parameter int H_ACTIVE = 640,
  parameter int H_FRONT  = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BACK   = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FRONT  = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BACK   = 33,
  parameter int SYNC_POL = 0,
  parameter int CW       = 12
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_pix_en,
  output logic          o_hsync,
  output logic          o_vsync,
  output logic          o_hblank,
  output logic          o_vblank,
  output logic          o_active,
  output logic [CW-1:0] o_x,
  output logic [CW-1:0] o_y,
  output logic          o_line_start,
  output logic          o_frame_start
`ifdef VGA_TIMING_FRAME_CNT_EN
  ,
  output logic [15:0]   o_frame_cnt
`endif
);

  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  // Region boundaries as counter-width constants. A sync window is the
  // half-open interval [SYNC_START, SYNC_END).
  localparam logic [CW-1:0] H_LAST       = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] H_BLANK_AT   = CW'(H_ACTIVE);
  localparam logic [CW-1:0] H_SYNC_START = CW'(H_ACTIVE + H_FRONT);
  localparam logic [CW-1:0] H_SYNC_END   = CW'(H_ACTIVE + H_FRONT + H_SYNC);

  localparam logic [CW-1:0] V_LAST       = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] V_BLANK_AT   = CW'(V_ACTIVE);
  localparam logic [CW-1:0] V_SYNC_START = CW'(V_ACTIVE + V_FRONT);
  localparam logic [CW-1:0] V_SYNC_END   = CW'(V_ACTIVE + V_FRONT + V_SYNC);

  localparam logic SYNC_ON = (SYNC_POL != 0);

  // Both totals must fit the coordinate width. Otherwise the wrap compare
  // would never match.
  if (H_TOTAL > (1 << CW) || V_TOTAL > (1 << CW)) begin : g_cw_check
    $error("vga_timing: H_TOTAL/V_TOTAL do not fit in CW bits");
  end

  // Sync output level for a position inside or outside the sync window.
  function automatic logic sync_level(input logic in_sync);
    return in_sync ? SYNC_ON : ~SYNC_ON;
  endfunction

  // Window membership test: lo <= c < hi.
  function automatic logic in_window(input logic [CW-1:0] c,
                                     input logic [CW-1:0] lo,
                                     input logic [CW-1:0] hi);
    return (c >= lo) && (c < hi);
  endfunction

  logic [CW-1:0] h_q, h_d;
  logic [CW-1:0] v_q, v_d;
  logic          hsync_q, hsync_d;
  logic          vsync_q, vsync_d;
  logic          hblank_q, hblank_d;
  logic          vblank_q, vblank_d;
  logic          active_q, active_d;
  logic          line_start_q, line_start_d;
  logic          frame_start_q, frame_start_d;
`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [15:0]   frame_cnt_q, frame_cnt_d;
`endif

  always_comb begin
    h_d           = h_q;
    v_d           = v_q;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;

    if (i_pix_en) begin
      if (h_q == H_LAST) begin
        h_d          = '0;
        line_start_d = 1'b1;
        if (v_q == V_LAST) begin
          v_d           = '0;
          frame_start_d = 1'b1;
        end else begin
          v_d = v_q + 1'b1;
        end
      end else begin
        h_d = h_q + 1'b1;
      end
    end

    // Decode from the next count so the flags register alongside it.
    hblank_d = (h_d >= H_BLANK_AT);
    vblank_d = (v_d >= V_BLANK_AT);
    active_d = ~hblank_d & ~vblank_d;
    hsync_d  = sync_level(in_window(h_d, H_SYNC_START, H_SYNC_END));
    vsync_d  = sync_level(in_window(v_d, V_SYNC_START, V_SYNC_END));

`ifdef VGA_TIMING_FRAME_CNT_EN
    frame_cnt_d = frame_start_d ? frame_cnt_q + 16'd1 : frame_cnt_q;
`endif
  end

  // Output register stage: reset parks the raster at (0,0) with no pulses.
  // A reset never produces a start pulse.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      h_q           <= '0;
      v_q           <= '0;
      hsync_q       <= ~SYNC_ON;
      vsync_q       <= ~SYNC_ON;
      hblank_q      <= 1'b0;
      vblank_q      <= 1'b0;
      active_q      <= 1'b1;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
`ifdef VGA_TIMING_FRAME_CNT_EN
      frame_cnt_q   <= 16'd0;
`endif
    end else begin
      h_q           <= h_d;
      v_q           <= v_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      hblank_q      <= hblank_d;
      vblank_q      <= vblank_d;
      active_q      <= active_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
`ifdef VGA_TIMING_FRAME_CNT_EN
      frame_cnt_q   <= frame_cnt_d;
`endif
    end
  end

  assign o_x           = h_q;
  assign o_y           = v_q;
  assign o_hsync       = hsync_q;
  assign o_vsync       = vsync_q;
  assign o_hblank      = hblank_q;
  assign o_vblank      = vblank_q;
  assign o_active      = active_q;
  assign o_line_start  = line_start_q;
  assign o_frame_start = frame_start_q;
`ifdef VGA_TIMING_FRAME_CNT_EN
  assign o_frame_cnt   = frame_cnt_q;
`endif

endmodule

// File: tb/tb_vga_timing.sv
// -----------------------------------------------------------------------------
// tb_vga_timing
//
// Self-checking bench for vga_timing with three instances:
//   dut_d : default 640x480 timing (horizontal regions, enable toggling,
//           mid-line reset)
//   dut_v : tiny horizontal (4/1/1/1) with default vertical timing, so full
//           frames and the 490..491 vsync window are reachable in few cycles
//   dut_s : small 4/1/1/1 x 3/1/1/1 with active-high sync (table vectors,
//           42-cycle frames, optional frame counter)
// -----------------------------------------------------------------------------
module tb_vga_timing;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic        rst_d, en_d, hs_d, vs_d, hb_d, vb_d, act_d, ls_d, fs_d;
  logic [11:0] x_d, y_d;
  logic        rst_v, en_v, hs_v, vs_v, hb_v, vb_v, act_v, ls_v, fs_v;
  logic [11:0] x_v, y_v;
  logic        rst_s, en_s, hs_s, vs_s, hb_s, vb_s, act_s, ls_s, fs_s;
  logic [11:0] x_s, y_s;
`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [15:0] fc_d, fc_v, fc_s;
`endif

  vga_timing dut_d (
    .i_clk(clk), .i_rst(rst_d), .i_pix_en(en_d),
    .o_hsync(hs_d), .o_vsync(vs_d), .o_hblank(hb_d), .o_vblank(vb_d),
    .o_active(act_d), .o_x(x_d), .o_y(y_d),
    .o_line_start(ls_d), .o_frame_start(fs_d)
`ifdef VGA_TIMING_FRAME_CNT_EN
    , .o_frame_cnt(fc_d)
`endif
  );

  vga_timing #(
    .H_ACTIVE(4), .H_FRONT(1), .H_SYNC(1), .H_BACK(1)
  ) dut_v (
    .i_clk(clk), .i_rst(rst_v), .i_pix_en(en_v),
    .o_hsync(hs_v), .o_vsync(vs_v), .o_hblank(hb_v), .o_vblank(vb_v),
    .o_active(act_v), .o_x(x_v), .o_y(y_v),
    .o_line_start(ls_v), .o_frame_start(fs_v)
`ifdef VGA_TIMING_FRAME_CNT_EN
    , .o_frame_cnt(fc_v)
`endif
  );

  vga_timing #(
    .H_ACTIVE(4), .H_FRONT(1), .H_SYNC(1), .H_BACK(1),
    .V_ACTIVE(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .SYNC_POL(1)
  ) dut_s (
    .i_clk(clk), .i_rst(rst_s), .i_pix_en(en_s),
    .o_hsync(hs_s), .o_vsync(vs_s), .o_hblank(hb_s), .o_vblank(vb_s),
    .o_active(act_s), .o_x(x_s), .o_y(y_s),
    .o_line_start(ls_s), .o_frame_start(fs_s)
`ifdef VGA_TIMING_FRAME_CNT_EN
    , .o_frame_cnt(fc_s)
`endif
  );

  // Directed vector: inputs for one edge and the outputs expected after it.
  // flags = {hsync, vsync, hblank, vblank, line_start, frame_start}
  typedef struct {
    logic        rst;
    logic        en;
    logic [11:0] x;
    logic [11:0] y;
    logic [5:0]  flags;
  } vec_t;

  localparam int NVEC = 16;
  vec_t tbl [NVEC];

  function automatic vec_t mk(input logic r, input logic e, input int x,
                              input int y, input logic [5:0] f);
    vec_t v;
    v.rst   = r;
    v.en    = e;
    v.x     = 12'(x);
    v.y     = 12'(y);
    v.flags = f;
    return v;
  endfunction

  function automatic logic [31:0] pk(input logic [11:0] x, input logic [11:0] y,
                                     input logic hs, input logic vs,
                                     input logic hb, input logic vb,
                                     input logic act, input logic ls,
                                     input logic fs);
    return {1'b0, x, y, hs, vs, hb, vb, act, ls, fs};
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  int mx, my, e, last, npulse, lowcnt, found, fs_seen;
  logic mls, mfs;
  logic [31:0] expv;

  initial begin
    rst_d = 1'b1; en_d = 1'b0;
    rst_v = 1'b1; en_v = 1'b0;
    rst_s = 1'b1; en_s = 1'b0;

    // ---------------- small instance: directed table ----------------
    tbl[0]  = mk(1'b1, 1'b0, 0, 0, 6'b000000);
    tbl[1]  = mk(1'b1, 1'b1, 0, 0, 6'b000000);  // reset beats enable
    tbl[2]  = mk(1'b0, 1'b0, 0, 0, 6'b000000);  // frozen, no exit pulse
    tbl[3]  = mk(1'b0, 1'b1, 1, 0, 6'b000000);
    tbl[4]  = mk(1'b0, 1'b1, 2, 0, 6'b000000);
    tbl[5]  = mk(1'b0, 1'b0, 2, 0, 6'b000000);  // hold
    tbl[6]  = mk(1'b0, 1'b1, 3, 0, 6'b000000);
    tbl[7]  = mk(1'b0, 1'b1, 4, 0, 6'b001000);  // front porch
    tbl[8]  = mk(1'b0, 1'b1, 5, 0, 6'b101000);  // hsync (active-high)
    tbl[9]  = mk(1'b0, 1'b1, 6, 0, 6'b001000);  // back porch
    tbl[10] = mk(1'b0, 1'b1, 0, 1, 6'b000010);  // line wrap pulse
    tbl[11] = mk(1'b0, 1'b0, 0, 1, 6'b000000);  // pulse drops while idle
    tbl[12] = mk(1'b0, 1'b1, 1, 1, 6'b000000);
    tbl[13] = mk(1'b1, 1'b1, 0, 0, 6'b000000);  // mid-line reset
    tbl[14] = mk(1'b0, 1'b0, 0, 0, 6'b000000);
    tbl[15] = mk(1'b0, 1'b1, 1, 0, 6'b000000);

    for (int i = 0; i < NVEC; i++) begin
      rst_s = tbl[i].rst;
      en_s  = tbl[i].en;
      cyc();
      expv = pk(tbl[i].x, tbl[i].y, tbl[i].flags[5], tbl[i].flags[4],
                tbl[i].flags[3], tbl[i].flags[2],
                ~tbl[i].flags[3] & ~tbl[i].flags[2],
                tbl[i].flags[1], tbl[i].flags[0]);
      chk($sformatf("s_tbl[%0d]", i),
          pk(x_s, y_s, hs_s, vs_s, hb_s, vb_s, act_s, ls_s, fs_s), expv);
    end

    // ---------------- small instance: three full frames ----------------
    rst_s = 1'b1; en_s = 1'b0;
    cyc();
    rst_s = 1'b0; en_s = 1'b1;
    mx = 0; my = 0; last = -1; npulse = 0;
    for (int n = 1; n <= 3 * 42 + 5; n++) begin
      cyc();
      mls = 1'b0; mfs = 1'b0;
      if (mx == 6) begin
        mx = 0; mls = 1'b1;
        if (my == 5) begin my = 0; mfs = 1'b1; end
        else my++;
      end else begin
        mx++;
      end
      expv = pk(12'(mx), 12'(my), mx == 5, my == 4, mx >= 4, my >= 3,
                (mx < 4) && (my < 3), mls, mfs);
      chk("s_run", pk(x_s, y_s, hs_s, vs_s, hb_s, vb_s, act_s, ls_s, fs_s), expv);
      if (fs_s) begin
        if (last >= 0) chk("s_frame_period", n - last, 42);
        last = n;
        npulse++;
      end
`ifdef VGA_TIMING_FRAME_CNT_EN
      chk("s_frame_cnt", 32'(fc_s), npulse);
`endif
    end
    chk("s_frame_pulses", npulse, 3);

`ifdef VGA_TIMING_FRAME_CNT_EN
    // Preload 65535; the next frame start must wrap it to zero.
    force dut_s.frame_cnt_q = 16'hFFFF;
    cyc();
    release dut_s.frame_cnt_q;
    found = 0;
    for (int n = 1; n <= 60; n++) begin
      cyc();
      if (fs_s) begin found = n; break; end
      chk("s_fc_hold", 32'(fc_s), 32'hFFFF);
    end
    chk("s_fc_found", found > 0, 1);
    chk("s_fc_wrap", 32'(fc_s), 0);
    cyc();
    chk("s_fc_after", 32'(fc_s), 0);
    rst_s = 1'b1;
    cyc();
    chk("s_fc_rst", 32'(fc_s), 0);
    rst_s = 1'b0;
`endif
    en_s = 1'b0;

    // ---------------- default instance: reset, continuous enable ----------------
    rst_d = 1'b1; en_d = 1'b0;
    cyc();
    chk("d_reset", pk(x_d, y_d, hs_d, vs_d, hb_d, vb_d, act_d, ls_d, fs_d),
        pk(12'd0, 12'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
`ifdef VGA_TIMING_FRAME_CNT_EN
    chk("d_reset_fc", 32'(fc_d), 0);
`endif
    rst_d = 1'b0; en_d = 1'b1;
    last = -1; npulse = 0;
    for (int n = 1; n <= 1700; n++) begin
      cyc();
      mx = n % 800; my = n / 800;
      expv = pk(12'(mx), 12'(my), !(mx >= 656 && mx <= 751), 1'b1,
                mx >= 640, 1'b0, mx < 640, mx == 0, 1'b0);
      chk("d_run", pk(x_d, y_d, hs_d, vs_d, hb_d, vb_d, act_d, ls_d, fs_d), expv);
      if (ls_d) begin
        if (last >= 0) chk("d_line_period", n - last, 800);
        last = n;
        npulse++;
      end
    end
    chk("d_line_pulses", npulse, 2);

    // ---------------- default instance: enable every other cycle ----------------
    rst_d = 1'b1; en_d = 1'b0;
    cyc();
    rst_d = 1'b0;
    e = 0; last = -1; npulse = 0;
    for (int k = 0; k < 3300; k++) begin
      en_d = (k % 2 == 0);
      cyc();
      if (en_d) e++;
      mx = e % 800; my = e / 800;
      expv = pk(12'(mx), 12'(my), !(mx >= 656 && mx <= 751), 1'b1,
                mx >= 640, 1'b0, mx < 640, en_d && (mx == 0), 1'b0);
      chk("d_toggle", pk(x_d, y_d, hs_d, vs_d, hb_d, vb_d, act_d, ls_d, fs_d), expv);
      if (ls_d) begin
        if (last >= 0) chk("d_toggle_period", k - last, 1600);
        last = k;
        npulse++;
      end
    end
    chk("d_toggle_pulses", npulse, 2);

    // ---------------- default instance: hold then mid-line reset ----------------
    rst_d = 1'b1; en_d = 1'b0;
    cyc();
    rst_d = 1'b0; en_d = 1'b1;
    repeat (1100) cyc();
    expv = pk(12'd300, 12'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("d_pos", pk(x_d, y_d, hs_d, vs_d, hb_d, vb_d, act_d, ls_d, fs_d), expv);
    en_d = 1'b0;
    for (int n = 0; n < 20; n++) begin
      cyc();
      chk("d_hold", pk(x_d, y_d, hs_d, vs_d, hb_d, vb_d, act_d, ls_d, fs_d), expv);
    end
    rst_d = 1'b1; en_d = 1'b1;
    cyc();
    chk("d_rst_mid", pk(x_d, y_d, hs_d, vs_d, hb_d, vb_d, act_d, ls_d, fs_d),
        pk(12'd0, 12'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
    rst_d = 1'b0;
    found = 0; fs_seen = 0;
    for (int n = 1; n <= 2000; n++) begin
      cyc();
      if (fs_d) fs_seen++;
      if (ls_d) begin found = n; break; end
    end
    chk("d_rst_line_start", found, 800);
    chk("d_rst_no_frame", fs_seen, 0);
    en_d = 1'b0;

    // ---------------- default vertical timing, tiny lines ----------------
    rst_v = 1'b1; en_v = 1'b0;
    cyc();
    chk("v_reset", pk(x_v, y_v, hs_v, vs_v, hb_v, vb_v, act_v, ls_v, fs_v),
        pk(12'd0, 12'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
    rst_v = 1'b0; en_v = 1'b1;
    last = -1; npulse = 0; lowcnt = 0;
    for (int n = 1; n <= 7360; n++) begin
      cyc();
      mx = n % 7; my = (n / 7) % 525;
      expv = pk(12'(mx), 12'(my), mx != 5, !(my == 490 || my == 491),
                mx >= 4, my >= 480, (mx < 4) && (my < 480),
                mx == 0, (mx == 0) && (my == 0));
      chk("v_run", pk(x_v, y_v, hs_v, vs_v, hb_v, vb_v, act_v, ls_v, fs_v), expv);
      if (!vs_v && n <= 3675) lowcnt++;
      if (fs_v) begin
        if (last >= 0) chk("v_frame_period", n - last, 3675);
        last = n;
        npulse++;
      end
    end
    chk("v_vsync_low_cycles", lowcnt, 14);
    chk("v_frame_pulses", npulse, 2);
`ifdef VGA_TIMING_FRAME_CNT_EN
    chk("v_frame_cnt", 32'(fc_v), 2);
`endif
    en_v = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vga_timing.md
Name: vga_timing

Overview:
- Single-clock VGA raster timing generator.
- Produces horizontal and vertical sync, blanking flags, and pixel x/y coordinates from one counter pair.
- Sits directly upstream of the pixel colour stage, replacing the separate hsync/vsync modules and their rippled vertical clock.
- The colour stage reads o_x, o_y and o_active in the same i_clk cycle and drives RGB from them.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BACK, 33, vertical back porch (lines)
- SYNC_POL, 0, sync asserted level (0 = active-low, 1 = active-high)
- CW, 12, coordinate counter width

Ports:
- i_clk  in  1  system clock
- i_rst  in  1  synchronous reset, active-high
- i_pix_en  in  1  pixel-rate enable (1 of every 2 i_clk cycles for 25 MHz from 50 MHz)
- o_hsync  out  1  horizontal sync, level per SYNC_POL
- o_vsync  out  1  vertical sync, level per SYNC_POL
- o_hblank  out  1  high when h count >= H_ACTIVE
- o_vblank  out  1  high when v count >= V_ACTIVE
- o_active  out  1  ~o_hblank & ~o_vblank
- o_x  out  CW  current h count, 0..H_TOTAL-1
- o_y  out  CW  current v count, 0..V_TOTAL-1
- o_line_start  out  1  one-cycle pulse when h wraps to 0
- o_frame_start  out  1  one-cycle pulse when (h,v) wraps to (0,0)
- o_frame_cnt  out  16  frames completed (only with VGA_TIMING_FRAME_CNT_EN)

Behaviour:
- H_TOTAL = H_ACTIVE+H_FRONT+H_SYNC+H_BACK (800); V_TOTAL likewise (525). Both must fit in CW bits.
- Counters update only on i_clk edges with i_pix_en=1 and i_rst=0.
  - h: 0 -> H_TOTAL-1 -> 0.
  - v: increments only when h wraps; V_TOTAL-1 -> 0.
- h regions:
  - ACTIVE: [0, H_ACTIVE)
  - FRONT: [H_ACTIVE, H_ACTIVE+H_FRONT)
  - SYNC: [H_ACTIVE+H_FRONT, +H_SYNC), i.e. 656..751 by default
  - BACK: remainder
- v regions: same scheme; default sync lines are 490..491.
- All outputs are registered and decoded from the next-count value. In any cycle, o_hsync/o_hblank/o_vsync/o_vblank/o_active correspond exactly to the o_x/o_y shown. There is no skew between coordinates and flags.
- Pulses:
  - o_line_start is 1 for exactly one i_clk cycle, the cycle after the enabled edge that moved h to 0.
  - o_frame_start is the same, but only when v also moved to 0. Both pulses are asserted together at frame wrap.
  - Both pulses are 0 in all other cycles, including while i_pix_en=0.
- Reset (sync, any time including mid-frame):
  - next cycle o_x=0, o_y=0, o_hblank=0, o_vblank=0, o_active=1
  - o_hsync=o_vsync=~SYNC_POL
  - o_line_start=o_frame_start=0; reset exit does not generate a start pulse
  - o_frame_cnt=0
- i_rst overrides i_pix_en in the same cycle.
- i_pix_en held 0: all counters and levels frozen indefinitely. Pulses drop after one cycle.
- i_pix_en=1 every cycle is legal; timing then runs at the i_clk rate.

Optional Feature:
- Macro VGA_TIMING_FRAME_CNT_EN.
- Defined:
  - o_frame_cnt port exists.
  - 16-bit counter increments in the same cycle o_frame_start asserts.
  - Wraps 65535 -> 0; reset to 0.
- Undefined: port and counter logic absent. All other behaviour is identical.

Test Plan:
- Reset, then i_pix_en=1 constantly:
  - o_hsync=0 for o_x 656..751 only
  - o_hblank=1 for o_x 640..799
  - o_line_start period 800 cycles
- Same run:
  - o_vsync=0 exactly for o_y 490..491 (1600 cycles)
  - o_vblank=1 for o_y 480..524
  - o_frame_start period 420000 cycles, coincident with o_line_start
- i_pix_en toggling every cycle:
  - line period 1600 i_clk and frame period 840000 i_clk
  - pulses 1 cycle wide
  - o_x holds for 2 cycles
- Assert i_rst for 1 cycle at (300,200):
  - next cycle (0,0), o_active=1, syncs high
  - no o_frame_start
  - next o_line_start 800 enabled edges later
- Small params (H 4/1/1/1, V 3/1/1/1, SYNC_POL=1):
  - o_hsync=1 only at o_x=5
  - o_vsync=1 only at o_y=4
  - frame = 42 cycles
- With VGA_TIMING_FRAME_CNT_EN and small params:
  - o_frame_cnt increments on each o_frame_start
  - force a value of 65535; the next frame wraps it to 0
  - i_rst clears it to 0
